// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcode/funct
// values, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_ADDI_WB   = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;

    // Which of the three MEM_ADDR users is in flight, captured at DECODE
    typedef enum logic [1:0] {
        MK_LW   = 2'd0,
        MK_SW   = 2'd1,
        MK_ADDI = 2'd2
    } mem_kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1111;
    localparam logic [3:0] ALU_SRL = 4'b1110;

    localparam logic [1:0] SRCA_PC = 2'b00;
    localparam logic [1:0] SRCA_A  = 2'b01;
    localparam logic [1:0] SRCA_B  = 2'b10;

    localparam logic [2:0] SRCB_B      = 3'b000;
    localparam logic [2:0] SRCB_FOUR   = 3'b001;
    localparam logic [2:0] SRCB_IMM    = 3'b010;
    localparam logic [2:0] SRCB_IMM_SH = 3'b011;
    localparam logic [2:0] SRCB_SHAMT  = 3'b100;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_control_decode.sv
// R-type funct decoder: ALU operation, shift-operand select and legality.
module alu_control_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       is_shift,
    output logic       legal
);

    // Map funct onto the ALU op; anything unrecognised is flagged illegal
    always_comb begin
        alu_control = ALU_AND;
        is_shift    = 1'b0;
        legal       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            FN_NOR:  alu_control = ALU_NOR;
            FN_SLL:  begin alu_control = ALU_SLL; is_shift = 1'b1; end
            FN_SRL:  begin alu_control = ALU_SRL; is_shift = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences each instruction, drives datapath
// strobes and aluControl, stalls on mem_ready and counts retired instructions.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zeroFlag,
    input  logic               mem_ready,
    output logic               memRead,
    output logic               memWrite,
    output logic               iorD,
    output logic               irWrite,
    output logic               regWrite,
    output logic               regDst,
    output logic               memToReg,
    output logic [1:0]         aluSrcA,
    output logic [2:0]         aluSrcB,
    output logic [3:0]         aluControl,
    output logic [1:0]         pcSrc,
    output logic               pcWrite,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    logic [3:0]         state_q, state_d;
    mem_kind_e          kind_q, kind_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               retire_s;
    logic               illegal_s;

    logic [3:0] dec_ctrl_s;
    logic       dec_shift_s;
    logic       dec_legal_s;

    logic       mem_read_s, mem_write_s, iord_s, ir_write_s, reg_write_s;
    logic       reg_dst_s, mem_to_reg_s, pc_write_s;
    logic [1:0] alu_src_a_s, pc_src_s;
    logic [2:0] alu_src_b_s;
    logic [3:0] alu_ctrl_s;

    alu_control_decode u_alu_dec (
        .funct       (funct),
        .alu_control (dec_ctrl_s),
        .is_shift    (dec_shift_s),
        .legal       (dec_legal_s)
    );

    // Next-state, retire and illegal-instruction detection
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        retire_s  = 1'b0;
        illegal_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: state_d = S_EXECUTE;
                    OP_LW:    begin state_d = S_MEM_ADDR; kind_d = MK_LW;   end
                    OP_SW:    begin state_d = S_MEM_ADDR; kind_d = MK_SW;   end
                    OP_ADDI:  begin state_d = S_MEM_ADDR; kind_d = MK_ADDI; end
                    OP_BEQ,
                    OP_BNE:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    default:  begin state_d = S_FETCH; illegal_s = 1'b1; end
                endcase
            end
            S_MEM_ADDR: begin
                case (kind_q)
                    MK_LW:   state_d = S_MEM_READ;
                    MK_SW:   state_d = S_MEM_WRITE;
                    default: state_d = S_ADDI_WB;
                endcase
            end
            S_MEM_READ: begin
                if (mem_ready) state_d = S_MEM_WB;
                else           state_d = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d  = S_MEM_WRITE;
                end
            end
            S_EXECUTE: begin
                if (dec_legal_s) begin
                    state_d = S_R_WB;
                end else begin
                    state_d   = S_FETCH;
                    illegal_s = 1'b1;
                end
            end
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        count_d = retire_s ? count_q + {{(COUNT_W-1){1'b0}}, 1'b1} : count_q;
    end

    // State, instruction class and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            kind_q  <= MK_LW;
            count_q <= {COUNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            count_q <= count_d;
        end
    end

    // Datapath controls decoded from the current state
    always_comb begin
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        iord_s       = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        pc_write_s   = 1'b0;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_B;
        alu_ctrl_s   = ALU_AND;
        pc_src_s     = PC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                alu_ctrl_s  = ALU_ADD;
                ir_write_s  = mem_ready;
                pc_write_s  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b_s = SRCB_IMM_SH;
                alu_ctrl_s  = ALU_ADD;
            end
            S_MEM_ADDR: begin
                alu_src_a_s = SRCA_A;
                alu_src_b_s = SRCB_IMM;
                alu_ctrl_s  = ALU_ADD;
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_s = dec_shift_s ? SRCA_B : SRCA_A;
                alu_src_b_s = dec_shift_s ? SRCB_SHAMT : SRCB_B;
                alu_ctrl_s  = dec_ctrl_s;
            end
            S_R_WB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s = SRCA_A;
                alu_ctrl_s  = ALU_SUB;
                pc_src_s    = PC_ALUOUT;
                pc_write_s  = (opcode == OP_BNE) ? ~zeroFlag : zeroFlag;
            end
            S_JUMP: begin
                pc_src_s   = PC_JUMP;
                pc_write_s = 1'b1;
            end
            default: begin
                alu_src_a_s = SRCA_PC;
            end
        endcase
    end

    // Requests and write strobes are held off for the whole time rst_n is low
    assign memRead     = mem_read_s  & rst_n;
    assign memWrite    = mem_write_s & rst_n;
    assign irWrite     = ir_write_s  & rst_n;
    assign regWrite    = reg_write_s & rst_n;
    assign pcWrite     = pc_write_s  & rst_n;
    assign illegal     = illegal_s   & rst_n;
    assign iorD        = iord_s;
    assign regDst      = reg_dst_s;
    assign memToReg    = mem_to_reg_s;
    assign aluSrcA     = alu_src_a_s;
    assign aluSrcB     = alu_src_b_s;
    assign aluControl  = alu_ctrl_s;
    assign pcSrc       = pc_src_s;
    assign instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: per-cycle expected control
// vectors are queued with their stimulus and compared at the falling edge.
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zeroFlag = 1'b0;
    logic        mem_ready = 1'b0;
    logic        memRead, memWrite, iorD, irWrite, regWrite, regDst, memToReg;
    logic [1:0]  aluSrcA, pcSrc;
    logic [2:0]  aluSrcB;
    logic [3:0]  aluControl;
    logic        pcWrite, illegal;
    logic [31:0] instr_count;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_cnt = 32'd0;

    typedef struct {
        string       nm;
        logic        rdy;
        logic        zf;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [19:0] ev;
        logic [31:0] ec;
    } item_t;

    item_t sb[$];
    item_t it;

    mips_multicycle_control #(.COUNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zeroFlag(zeroFlag), .mem_ready(mem_ready),
        .memRead(memRead), .memWrite(memWrite), .iorD(iorD), .irWrite(irWrite),
        .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluControl(aluControl),
        .pcSrc(pcSrc), .pcWrite(pcWrite), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    wire [19:0] out_vec = {memRead, memWrite, iorD, irWrite, regWrite, regDst, memToReg,
                           aluSrcA, aluSrcB, aluControl, pcSrc, pcWrite, illegal};

    // Field order: memRead memWrite iorD irWrite regWrite regDst memToReg aluSrcA aluSrcB aluControl pcSrc pcWrite illegal
    function automatic logic [19:0] v(input logic mr, mw, io, irw, rw, rd, m2r,
                                      input logic [1:0] sa, input logic [2:0] sbs,
                                      input logic [3:0] ac, input logic [1:0] ps,
                                      input logic pw, il);
        return {mr, mw, io, irw, rw, rd, m2r, sa, sbs, ac, ps, pw, il};
    endfunction

    task automatic push(input string nm, input logic rdy, input logic zf,
                        input logic [5:0] op, input logic [5:0] fn, input logic [19:0] ev);
        item_t x;
        x.nm = nm; x.rdy = rdy; x.zf = zf; x.op = op; x.fn = fn; x.ev = ev; x.ec = exp_cnt;
        sb.push_back(x);
    endtask

    function automatic logic [19:0] e_fetch(input logic rdy);
        return v(1'b1,1'b0,1'b0,rdy,1'b0,1'b0,1'b0, 2'b00,3'b001,4'b0010,2'b00, rdy,1'b0);
    endfunction
    function automatic logic [19:0] e_decode(input logic il);
        return v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,3'b011,4'b0010,2'b00,1'b0, il);
    endfunction

    task automatic test_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            total++;
            if ({out_vec, instr_count} !== {v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b001,4'b0010,2'b00,1'b0,1'b0), 32'd0}) begin
                $display("FAIL reset_hold: got vec=%b cnt=%0d, expected vec=%b cnt=0", out_vec, instr_count,
                         v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b001,4'b0010,2'b00,1'b0,1'b0));
            end else passed++;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        push("lw_fetch",   1'b1, 1'b0, 6'b100011, 6'd0, e_fetch(1'b1));
        push("lw_decode",  1'b1, 1'b0, 6'b100011, 6'd0, e_decode(1'b0));
        push("lw_memaddr", 1'b1, 1'b0, 6'b100011, 6'd0, v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010,4'b0010,2'b00,1'b0,1'b0));
        push("lw_memread", 1'b1, 1'b0, 6'b100011, 6'd0, v(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,4'b0000,2'b00,1'b0,1'b0));
        push("lw_memwb",   1'b1, 1'b0, 6'b100011, 6'd0, v(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,3'b000,4'b0000,2'b00,1'b0,1'b0));
        exp_cnt++;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.rdy; zeroFlag = it.zf; opcode = it.op; funct = it.fn;
            @(negedge clk);
            total++;
            if ({out_vec, instr_count} !== {it.ev, it.ec})
                $display("FAIL %s: got vec=%b cnt=%0d, expected vec=%b cnt=%0d", it.nm, out_vec, instr_count, it.ev, it.ec);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        push("sub_fetch",  1'b1, 1'b0, 6'b000000, 6'b100010, e_fetch(1'b1));
        push("sub_decode", 1'b1, 1'b0, 6'b000000, 6'b100010, e_decode(1'b0));
        push("sub_exec",   1'b1, 1'b0, 6'b000000, 6'b100010, v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,4'b0110,2'b00,1'b0,1'b0));
        push("sub_rwb",    1'b1, 1'b0, 6'b000000, 6'b100010, v(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,4'b0000,2'b00,1'b0,1'b0));
        exp_cnt++;
        push("sll_fetch",  1'b1, 1'b0, 6'b000000, 6'b000000, e_fetch(1'b1));
        push("sll_decode", 1'b1, 1'b0, 6'b000000, 6'b000000, e_decode(1'b0));
        push("sll_exec",   1'b1, 1'b0, 6'b000000, 6'b000000, v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,3'b100,4'b1111,2'b00,1'b0,1'b0));
        push("sll_rwb",    1'b1, 1'b0, 6'b000000, 6'b000000, v(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,4'b0000,2'b00,1'b0,1'b0));
        exp_cnt++;
        push("srl_fetch",  1'b1, 1'b0, 6'b000000, 6'b000010, e_fetch(1'b1));
        push("srl_decode", 1'b1, 1'b0, 6'b000000, 6'b000010, e_decode(1'b0));
        push("srl_exec",   1'b1, 1'b0, 6'b000000, 6'b000010, v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,3'b100,4'b1110,2'b00,1'b0,1'b0));
        push("srl_rwb",    1'b1, 1'b0, 6'b000000, 6'b000010, v(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,4'b0000,2'b00,1'b0,1'b0));
        exp_cnt++;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.rdy; zeroFlag = it.zf; opcode = it.op; funct = it.fn;
            @(negedge clk);
            total++;
            if ({out_vec, instr_count} !== {it.ev, it.ec})
                $display("FAIL %s: got vec=%b cnt=%0d, expected vec=%b cnt=%0d", it.nm, out_vec, instr_count, it.ev, it.ec);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [5:0]  ops [3];
        logic        zfs [3];
        logic [19:0] bv;
        ops[0] = 6'b000100; zfs[0] = 1'b1;
        ops[1] = 6'b000101; zfs[1] = 1'b1;
        ops[2] = 6'b000100; zfs[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bv = v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,4'b0110,2'b01,(k == 0),1'b0);
            push("br_fetch",  1'b1, zfs[k], ops[k], 6'd0, e_fetch(1'b1));
            push("br_decode", 1'b1, zfs[k], ops[k], 6'd0, e_decode(1'b0));
            push("br_branch", 1'b1, zfs[k], ops[k], 6'd0, bv);
            exp_cnt++;
        end
        push("j_fetch",  1'b1, 1'b0, 6'b000010, 6'd0, e_fetch(1'b1));
        push("j_decode", 1'b1, 1'b0, 6'b000010, 6'd0, e_decode(1'b0));
        push("j_jump",   1'b1, 1'b0, 6'b000010, 6'd0, v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,4'b0000,2'b10,1'b1,1'b0));
        exp_cnt++;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.rdy; zeroFlag = it.zf; opcode = it.op; funct = it.fn;
            @(negedge clk);
            total++;
            if ({out_vec, instr_count} !== {it.ev, it.ec})
                $display("FAIL %s: got vec=%b cnt=%0d, expected vec=%b cnt=%0d", it.nm, out_vec, instr_count, it.ev, it.ec);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall();
        push("sw_fetch",   1'b1, 1'b0, 6'b101011, 6'd0, e_fetch(1'b1));
        push("sw_decode",  1'b0, 1'b0, 6'b101011, 6'd0, e_decode(1'b0));
        push("sw_memaddr", 1'b0, 1'b0, 6'b101011, 6'd0, v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010,4'b0010,2'b00,1'b0,1'b0));
        for (int i = 0; i < 4; i++)
            push("sw_memwrite", (i == 3), 1'b0, 6'b101011, 6'd0, v(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,4'b0000,2'b00,1'b0,1'b0));
        exp_cnt++;
        push("sw_next_fetch", 1'b0, 1'b0, 6'b101011, 6'd0, e_fetch(1'b0));
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.rdy; zeroFlag = it.zf; opcode = it.op; funct = it.fn;
            @(negedge clk);
            total++;
            if ({out_vec, instr_count} !== {it.ev, it.ec})
                $display("FAIL %s: got vec=%b cnt=%0d, expected vec=%b cnt=%0d", it.nm, out_vec, instr_count, it.ev, it.ec);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        push("badop_fetch",  1'b1, 1'b0, 6'b111111, 6'd0, e_fetch(1'b1));
        push("badop_decode", 1'b1, 1'b0, 6'b111111, 6'd0, e_decode(1'b1));
        push("badfn_fetch",  1'b1, 1'b0, 6'b000000, 6'b111111, e_fetch(1'b1));
        push("badfn_decode", 1'b1, 1'b0, 6'b000000, 6'b111111, e_decode(1'b0));
        push("badfn_exec",   1'b1, 1'b0, 6'b000000, 6'b111111, v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,4'b0000,2'b00,1'b0,1'b1));
        push("badfn_after",  1'b0, 1'b0, 6'b000000, 6'b111111, e_fetch(1'b0));
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.rdy; zeroFlag = it.zf; opcode = it.op; funct = it.fn;
            @(negedge clk);
            total++;
            if ({out_vec, instr_count} !== {it.ev, it.ec})
                $display("FAIL %s: got vec=%b cnt=%0d, expected vec=%b cnt=%0d", it.nm, out_vec, instr_count, it.ev, it.ec);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        push("addi_fetch_wait", 1'b0, 1'b0, 6'b001000, 6'd0, e_fetch(1'b0));
        push("addi_fetch",      1'b1, 1'b0, 6'b001000, 6'd0, e_fetch(1'b1));
        push("addi_decode",     1'b1, 1'b0, 6'b001000, 6'd0, e_decode(1'b0));
        push("addi_memaddr",    1'b1, 1'b0, 6'b001000, 6'd0, v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010,4'b0010,2'b00,1'b0,1'b0));
        push("addi_wb",         1'b1, 1'b0, 6'b001000, 6'd0, v(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,4'b0000,2'b00,1'b0,1'b0));
        exp_cnt++;
        push("lw2_fetch",   1'b1, 1'b0, 6'b100011, 6'd0, e_fetch(1'b1));
        push("lw2_decode",  1'b1, 1'b0, 6'b100011, 6'd0, e_decode(1'b0));
        push("lw2_memaddr", 1'b1, 1'b0, 6'b100011, 6'd0, v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010,4'b0010,2'b00,1'b0,1'b0));
        for (int i = 0; i < 2; i++)
            push("lw2_memread_stall", 1'b0, 1'b0, 6'b100011, 6'd0, v(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,4'b0000,2'b00,1'b0,1'b0));
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.rdy; zeroFlag = it.zf; opcode = it.op; funct = it.fn;
            @(negedge clk);
            total++;
            if ({out_vec, instr_count} !== {it.ev, it.ec})
                $display("FAIL %s: got vec=%b cnt=%0d, expected vec=%b cnt=%0d", it.nm, out_vec, instr_count, it.ev, it.ec);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    // Entered with the DUT still stalled in MEM_READ from the previous task
    task automatic test_reset_midstall();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_vec, instr_count} !== {v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b001,4'b0010,2'b00,1'b0,1'b0), 32'd0})
            $display("FAIL reset_midstall: got vec=%b cnt=%0d, expected vec=%b cnt=0", out_vec, instr_count,
                     v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b001,4'b0010,2'b00,1'b0,1'b0));
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_cnt = 32'd0;
        push("post_reset_fetch_wait", 1'b0, 1'b0, 6'b100011, 6'd0, e_fetch(1'b0));
        push("post_reset_fetch",      1'b1, 1'b0, 6'b100011, 6'd0, e_fetch(1'b1));
        push("post_reset_decode",     1'b1, 1'b0, 6'b100011, 6'd0, e_decode(1'b0));
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.rdy; zeroFlag = it.zf; opcode = it.op; funct = it.fn;
            @(negedge clk);
            total++;
            if ({out_vec, instr_count} !== {it.ev, it.ec})
                $display("FAIL %s: got vec=%b cnt=%0d, expected vec=%b cnt=%0d", it.nm, out_vec, instr_count, it.ev, it.ec);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_sw_stall();
        test_illegal();
        test_back_to_back();
        test_reset_midstall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
